// File: rtl/ton_tran_det_mc.sv
// Multi-channel G.726 tone / transition detector.
// One shared datapath, per-channel delayed TD flag.
module ton_tran_det_mc #(
  parameter int          NCH      = 32,
  parameter int          CHW      = 5,
  parameter logic [15:0] TONE_THR = 16'hD200
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [15:0]    A2P,
  input  logic [18:0]    YL,
  input  logic [15:0]    DQ,
  input  logic           td_clr_all,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic           TDP,
  output logic           TR,
  output logic           ch_err
);

  logic [NCH-1:0] td;
  logic           in_range;
  logic           tdp;
  logic           tr;
  logic [3:0]     ylint;
  logic [4:0]     ylfrac;
  logic [15:0]    thr2;
  logic [15:0]    dqthr;
  logic           unused_bits;

  assign in_range = 32'(in_ch) < NCH;
  assign tdp      = $signed(A2P) < $signed(TONE_THR);
  assign ylint    = YL[18:15];
  assign ylfrac   = YL[14:10];

  // Max shifted value is 63<<9 = 32256, so 16 bits never overflow.
  always_comb begin
    thr2 = 16'({1'b1, ylfrac}) << ylint;
    if (ylint > 4'd9)
      thr2 = 16'd31744;
  end

  assign dqthr = (thr2 + (thr2 >> 1)) >> 1;
  assign tr    = td[in_ch] & ({1'b0, DQ[14:0]} > dqthr);

  assign unused_bits = ^{YL[9:0], DQ[15]};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      TDP       <= 1'b0;
      TR        <= 1'b0;
      ch_err    <= 1'b0;
      td        <= '0;
    end else begin
      out_valid <= 1'b0;
      ch_err    <= 1'b0;
      if (in_valid) begin
        if (in_range) begin
          out_valid <= 1'b1;
          out_ch    <= in_ch;
          TDP       <= tdp;
          TR        <= tr;
          td[in_ch] <= tr ? 1'b0 : tdp;
        end else begin
          ch_err <= 1'b1;
        end
      end
      // Global clear wins over the per-sample TD write above.
      if (td_clr_all)
        td <= '0;
    end
  end

endmodule

// File: tb/tb_ton_tran_det_mc.sv
// Scoreboard bench for ton_tran_det_mc.
// Reference model keeps its own TD array.
module tb_ton_tran_det_mc;

  localparam int NCH = 24;
  localparam int CHW = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic [15:0]    A2P = '0;
  logic [18:0]    YL = '0;
  logic [15:0]    DQ = '0;
  logic           td_clr_all = 1'b0;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic           TDP;
  logic           TR;
  logic           ch_err;

  ton_tran_det_mc #(
    .NCH(NCH),
    .CHW(CHW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ch(in_ch),
    .A2P(A2P),
    .YL(YL),
    .DQ(DQ),
    .td_clr_all(td_clr_all),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .TDP(TDP),
    .TR(TR),
    .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vld;
    bit err;
    bit full;
    int ch;
    bit tdp;
    bit tr;
  } exp_t;

  exp_t sb[$];
  bit   m_td[NCH];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int ref_dqthr(input logic [18:0] yl);
    int yi;
    int thr;
    yi = int'(yl[18:15]);
    if (yi > 9) thr = 31744;
    else thr = (32 + int'(yl[14:10])) * (1 << yi);
    return (3 * thr) / 4;
  endfunction

  task automatic drive(input bit v, input int ch,
                       input logic [15:0] a2p,
                       input logic [18:0] yl,
                       input logic [15:0] dq,
                       input bit clr, input bit rst);
    exp_t e;
    int   mag;
    e = '{default: 0};
    reset      = rst;
    in_valid   = v;
    in_ch      = CHW'(ch);
    A2P        = a2p;
    YL         = yl;
    DQ         = dq;
    td_clr_all = clr;
    mag = int'(dq[14:0]);
    if (rst) begin
      e.full = 1;
    end else if (v && ch < NCH) begin
      e.vld  = 1;
      e.full = 1;
      e.ch   = ch;
      e.tdp  = (int'($signed(a2p)) < -11776);
      e.tr   = m_td[ch] && (mag > ref_dqthr(yl));
    end else if (v) begin
      e.err = 1;
    end
    @(posedge clk);
    if (rst || clr) begin
      foreach (m_td[i]) m_td[i] = 0;
    end else if (e.vld) begin
      m_td[ch] = e.tr ? 1'b0 : e.tdp;
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 19'h0, 16'h0, 0, 0);
  endtask

  task automatic samp(input int ch, input logic [15:0] a2p,
                      input logic [18:0] yl,
                      input logic [15:0] dq);
    drive(1, ch, a2p, yl, dq, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.vld));
      chk("ch_err", 32'(ch_err), 32'(e.err));
      if (e.full) begin
        chk("out_ch", 32'(out_ch), 32'(e.ch));
        chk("TDP", 32'(TDP), 32'(e.tdp));
        chk("TR", 32'(TR), 32'(e.tr));
      end
    end
  end

  initial begin
    foreach (m_td[i]) m_td[i] = 0;
    drive(0, 0, 16'h0, 19'h0, 16'h0, 0, 1);
    drive(0, 0, 16'h0, 19'h0, 16'h0, 0, 1);
    idle();
    idle();

    // probe all channels: no tone, no transition
    for (int c = 0; c < NCH; c++)
      samp(c, 16'h0000, 19'h0, 16'h7FFF);

    // tone then transition on ch3
    samp(3, 16'hD000, 19'h0, 16'h0000);
    chk("t2_tdp", 32'(TDP), 32'd1);
    samp(3, 16'h0000, 19'h0, 16'h0019);
    chk("t2_tr", 32'(TR), 32'd1);
    samp(3, 16'h0000, 19'h0, 16'h0019);
    chk("t2_tr_clr", 32'(TR), 32'd0);

    // interleave ch3 (tone) and ch5 (at threshold)
    for (int i = 0; i < 4; i++) begin
      samp(3, 16'hD000, 19'h0, 16'h0000);
      samp(5, 16'hD200, 19'h0, 16'h0000);
    end
    samp(3, 16'h0000, 19'h0, 16'h0019);
    chk("t3_ch3", 32'(TR), 32'd1);
    samp(5, 16'h0000, 19'h0, 16'h0019);
    chk("t3_ch5", 32'(TR), 32'd0);

    // saturated scale factor threshold on ch0
    samp(0, 16'hD000, 19'h0, 16'h0000);
    samp(0, 16'h0000, 19'h7FFFF, 16'h5D00);
    chk("t4_edge", 32'(TR), 32'd0);
    samp(0, 16'hD000, 19'h0, 16'h0000);
    samp(0, 16'h0000, 19'h7FFFF, 16'hDD01);
    chk("t4_over", 32'(TR), 32'd1);
    samp(4, 16'h0000, 19'h2_8000, 16'h0180);

    // out-of-range channel leaves TD alone
    samp(1, 16'hD000, 19'h0, 16'h0000);
    samp(NCH, 16'h0000, 19'h0, 16'h7FFF);
    chk("t5_err", 32'(ch_err), 32'd1);
    samp(31, 16'hD000, 19'h0, 16'h7FFF);
    samp(1, 16'h0000, 19'h0, 16'h0019);
    chk("t5_tr1", 32'(TR), 32'd1);
    samp(2, 16'h0000, 19'h0, 16'h7FFF);
    chk("t5_tr2", 32'(TR), 32'd0);

    // global clear vs coincident sample
    samp(7, 16'hD000, 19'h0, 16'h0000);
    drive(1, 7, 16'hD000, 19'h0, 16'h7FFF, 1, 0);
    chk("t6_tr", 32'(TR), 32'd1);
    samp(7, 16'hD000, 19'h0, 16'h7FFF);
    chk("t6_after", 32'(TR), 32'd0);

    // reset mid-stream
    samp(7, 16'hD000, 19'h0, 16'h0000);
    samp(9, 16'hD000, 19'h0, 16'h0000);
    drive(1, 9, 16'hD000, 19'h0, 16'h7FFF, 0, 1);
    chk("t6_rst_vld", 32'(out_valid), 32'd0);
    samp(7, 16'h0000, 19'h0, 16'h7FFF);
    chk("t6_rst_tr7", 32'(TR), 32'd0);
    samp(9, 16'h0000, 19'h0, 16'h7FFF);
    chk("t6_rst_tr9", 32'(TR), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [18:0] y;
      logic [15:0] d;
      a = 16'($urandom_range(16'hC000, 16'hE000));
      y = 19'($urandom);
      d = 16'($urandom);
      drive(($urandom_range(0, 7) != 0),
            int'($urandom_range(0, 31)),
            a, y, d,
            ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 150) == 0));
    end

    idle();
    idle();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
